// File: rtl/conv_core_seq.sv
// rtl/conv_core_seq.sv - 3x3 stride-1 signed convolution engine, one MAC per cycle
//
// Loads a pre-padded ifmap (c, row, col order) and then a weight set
// (o, c, kh, kw order) over one valid/ready input stream. It then computes each
// output pixel with 9*IC multiply-accumulates. Each pixel is rounded half up,
// saturated to DW bits and streamed out with full back-pressure, in o-major
// order, then row, then column.
//
// Optional feature: define CONV_CORE_RELU_EN to clamp negative results to 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse in IDLE: latch cfg_* and begin a job
//   cfg_hp, cfg_wp    padded height / width (3..MAX_HW)
//   cfg_ic, cfg_oc    input / output channel counts
//   din_valid/ready   input word handshake (ready only while loading)
//   din_data          ifmap word, then weight word (signed)
//   dout_valid/ready  output pixel handshake
//   dout_data         output pixel (signed, or >= 0 with ReLU)
//   busy              high outside IDLE
//   done              one-cycle pulse after the last output handshake
//   cfg_err           sticky flag for a rejected config; cleared by an accepted start
module conv_core_seq #(
  parameter int DW     = 16,
  parameter int FRAC   = 10,
  parameter int MAX_HW = 12,
  parameter int MAX_IC = 12,
  parameter int MAX_OC = 12,
  parameter int ACC_W  = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    cfg_hp,
  input  logic [4:0]    cfg_wp,
  input  logic [7:0]    cfg_ic,
  input  logic [7:0]    cfg_oc,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam int PLANE    = MAX_HW * MAX_HW;
  localparam int IF_DEPTH = MAX_IC * PLANE;
  localparam int W_DEPTH  = MAX_OC * MAX_IC * 9;
  localparam int IF_AW    = $clog2(IF_DEPTH);
  localparam int W_AW     = $clog2(W_DEPTH);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_IF, S_LOAD_W, S_CALC, S_EMIT} state_t;

  state_t state;

  logic signed [DW-1:0] ifmap_mem [IF_DEPTH];
  logic signed [DW-1:0] wgt_mem   [W_DEPTH];

  logic [4:0]  hp_q, wp_q;
  logic [7:0]  ic_q, oc_q;
  // c_q is shared: channel index while loading the ifmap and while computing.
  logic [7:0]  c_q;
  logic [4:0]  r_q, x_q;
  logic [W_AW-1:0] lin_q;
  logic [1:0]  kh_q, kw_q;
  logic [7:0]  o_q;
  logic [4:0]  h_q, w_q;
  logic signed [ACC_W-1:0] acc_q;

  logic cfg_ok, din_hs, dout_hs;
  logic if_last, w_last, mac_first, mac_last;
  logic w_end, h_end, o_end;
  logic [IF_AW-1:0] if_wr_addr, if_rd_addr;
  logic [W_AW-1:0]  w_rd_addr;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext, acc_rnd;
  logic [DW-1:0] res;

  assign cfg_ok = (cfg_hp >= 5'd3) && (int'(cfg_hp) <= MAX_HW) &&
                  (cfg_wp >= 5'd3) && (int'(cfg_wp) <= MAX_HW) &&
                  (cfg_ic >= 8'd1) && (int'(cfg_ic) <= MAX_IC) &&
                  (cfg_oc >= 8'd1) && (int'(cfg_oc) <= MAX_OC);

  assign din_hs  = din_valid && din_ready;
  assign dout_hs = dout_valid && dout_ready;

  assign if_last   = (c_q == ic_q - 8'd1) && (r_q == hp_q - 5'd1) && (x_q == wp_q - 5'd1);
  assign w_last    = (lin_q == W_AW'(int'(oc_q) * int'(ic_q) * 9 - 1));
  assign mac_first = (c_q == 8'd0) && (kh_q == 2'd0) && (kw_q == 2'd0);
  assign mac_last  = (c_q == ic_q - 8'd1) && (kh_q == 2'd2) && (kw_q == 2'd2);
  // Output extent is Wp-2 by Hp-2, so the last index is Wp-3 / Hp-3.
  assign w_end = (w_q == wp_q - 5'd3);
  assign h_end = (h_q == hp_q - 5'd3);
  assign o_end = (o_q == oc_q - 8'd1);

  // The ifmap uses a fixed MAX_HW row pitch, so a window address depends only
  // on the counters and not on the runtime width.
  assign if_wr_addr = IF_AW'(int'(c_q) * PLANE + int'(r_q) * MAX_HW + int'(x_q));
  assign if_rd_addr = IF_AW'(int'(c_q) * PLANE + (int'(h_q) + int'(kh_q)) * MAX_HW
                             + int'(w_q) + int'(kw_q));
  // Weights are packed densely in arrival order: ((o*IC + c)*3 + kh)*3 + kw.
  assign w_rd_addr  = W_AW'((int'(o_q) * int'(ic_q) + int'(c_q)) * 9
                            + int'(kh_q) * 3 + int'(kw_q));

  assign prod     = ifmap_mem[if_rd_addr] * wgt_mem[w_rd_addr];
  assign prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};

  always_comb begin
    acc_rnd = (acc_q + RND_HALF) >>> FRAC;
    if (acc_rnd > SAT_MAX)      res = SAT_MAX[DW-1:0];
    else if (acc_rnd < SAT_MIN) res = SAT_MIN[DW-1:0];
    else                        res = acc_rnd[DW-1:0];
`ifdef CONV_CORE_RELU_EN
    if (res[DW-1]) res = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD_IF && din_hs) ifmap_mem[if_wr_addr] <= din_data;
    if (state == S_LOAD_W && din_hs)  wgt_mem[lin_q] <= din_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      din_ready <= 1'b0; dout_valid <= 1'b0; dout_data <= '0;
      busy <= 1'b0; done <= 1'b0; cfg_err <= 1'b0;
      hp_q <= '0; wp_q <= '0; ic_q <= '0; oc_q <= '0;
      c_q <= '0; r_q <= '0; x_q <= '0; lin_q <= '0;
      kh_q <= '0; kw_q <= '0; o_q <= '0; h_q <= '0; w_q <= '0;
      acc_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              hp_q <= cfg_hp; wp_q <= cfg_wp; ic_q <= cfg_ic; oc_q <= cfg_oc;
              c_q <= '0; r_q <= '0; x_q <= '0;
              cfg_err <= 1'b0; busy <= 1'b1; din_ready <= 1'b1;
              state <= S_LOAD_IF;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD_IF: begin
          if (din_hs) begin
            if (if_last) begin
              c_q <= '0; r_q <= '0; x_q <= '0; lin_q <= '0;
              state <= S_LOAD_W;
            end else if (x_q == wp_q - 5'd1) begin
              x_q <= '0;
              if (r_q == hp_q - 5'd1) begin
                r_q <= '0;
                c_q <= c_q + 8'd1;
              end else begin
                r_q <= r_q + 5'd1;
              end
            end else begin
              x_q <= x_q + 5'd1;
            end
          end
        end
        S_LOAD_W: begin
          if (din_hs) begin
            if (w_last) begin
              din_ready <= 1'b0;
              o_q <= '0; h_q <= '0; w_q <= '0;
              c_q <= '0; kh_q <= '0; kw_q <= '0;
              state <= S_CALC;
            end else begin
              lin_q <= lin_q + W_AW'(1);
            end
          end
        end
        S_CALC: begin
          // The first tap of a pixel overwrites the previous pixel's sum.
          acc_q <= mac_first ? prod_ext : acc_q + prod_ext;
          if (mac_last) begin
            c_q <= '0; kh_q <= '0; kw_q <= '0;
            state <= S_EMIT;
          end else if (kw_q == 2'd2) begin
            kw_q <= '0;
            if (kh_q == 2'd2) begin
              kh_q <= '0;
              c_q <= c_q + 8'd1;
            end else begin
              kh_q <= kh_q + 2'd1;
            end
          end else begin
            kw_q <= kw_q + 2'd1;
          end
        end
        S_EMIT: begin
          // One cycle to register the rounded result, then hold until taken.
          if (!dout_valid) begin
            dout_valid <= 1'b1;
            dout_data <= res;
          end else if (dout_ready) begin
            dout_valid <= 1'b0;
            if (w_end && h_end && o_end) begin
              busy <= 1'b0; done <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_CALC;
              if (!w_end) begin
                w_q <= w_q + 5'd1;
              end else begin
                w_q <= '0;
                if (!h_end) begin
                  h_q <= h_q + 5'd1;
                end else begin
                  h_q <= '0;
                  o_q <= o_q + 8'd1;
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_core_seq.sv
// tb/tb_conv_core_seq.sv - randomized self-checking bench for conv_core_seq
module tb_conv_core_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  cfg_hp = '0, cfg_wp = '0;
  logic [7:0]  cfg_ic = '0, cfg_oc = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] din_data = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [15:0] dout_data;
  logic        busy, done, cfg_err;

  conv_core_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_hp(cfg_hp), .cfg_wp(cfg_wp), .cfg_ic(cfg_ic), .cfg_oc(cfg_oc),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] words[$];
  longint      exp_q[$];
  int          last_hs;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sval(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: direct 3x3 correlation over the words in arrival order.
  task automatic build_model(input int hp, input int wp, input int ic, input int oc);
    longint acc, r;
    exp_q.delete();
    for (int o = 0; o < oc; o++)
      for (int h = 0; h < hp - 2; h++)
        for (int w = 0; w < wp - 2; w++) begin
          acc = 0;
          for (int c = 0; c < ic; c++)
            for (int kh = 0; kh < 3; kh++)
              for (int kw = 0; kw < 3; kw++)
                acc += sval(words[c*hp*wp + (h+kh)*wp + w + kw]) *
                       sval(words[ic*hp*wp + ((o*ic + c)*3 + kh)*3 + kw]);
          r = (acc + 512) >>> 10;
          if (r > 32767) r = 32767;
          if (r < -32768) r = -32768;
`ifdef CONV_CORE_RELU_EN
          if (r < 0) r = 0;
`else
`endif
          exp_q.push_back(r);
        end
  endtask

  task automatic make_words(input int hp, input int wp, input int ic, input int oc, input bit ones);
    words.delete();
    for (int i = 0; i < ic*hp*wp + oc*ic*9; i++)
      words.push_back(ones ? 16'h0400 : 16'($signed($urandom_range(0, 4095)) - 2048));
  endtask

  task automatic start_and_load(input int hp, input int wp, input int ic, input int oc, input int mode);
    int idx, cnt, total;
    total = ic*hp*wp + oc*ic*9;
    @(negedge clk);
    start = 1'b1; cfg_hp = 5'(hp); cfg_wp = 5'(wp); cfg_ic = 8'(ic); cfg_oc = 8'(oc);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", longint'(busy), 1);
    check_eq("cfg_err_cleared", longint'(cfg_err), 0);
    idx = 0; cnt = 0;
    while (idx < total && cnt < total*8 + 100) begin
      din_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      din_data = words[idx];
      if (din_valid && din_ready) begin
        idx++;
        last_hs = cyc + 1;
      end
      @(negedge clk);
      cnt++;
    end
    din_valid = 1'b0;
    check_eq("words_accepted", idx, total);
    check_eq("din_ready_after_last", longint'(din_ready), 0);
  endtask

  // mode 0: ready always high; 1: 1010 toggle plus 20-cycle stall; 2: random,
  // with stray din_valid and start pulses that must be ignored.
  task automatic collect(input int ic, input int mode);
    int got, cnt, hs_edge, dones, stall, npix;
    bit prev_v, prev_rdy, rdy;
    logic [15:0] prev_d;
    npix = exp_q.size();
    got = 0; cnt = 0; dones = 0; stall = 0; hs_edge = last_hs;
    prev_v = 0; prev_rdy = 0; prev_d = '0;
    while (got < npix && cnt < npix*(9*ic + 40) + 200) begin
      if (done) dones++;
      din_valid = $urandom_range(0, 1);
      din_data = 16'($urandom);
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      if (dout_valid) begin
        if (!prev_v) check_eq("latency", cyc - hs_edge, 9*ic + 1);
        else if (!prev_rdy) check_eq("hold_stable", longint'(dout_data), longint'(prev_d));
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) begin
          if (got == 1 && stall < 20) begin rdy = 1'b0; stall++; end
          else rdy = cyc[0];
        end else rdy = ($urandom_range(0, 2) != 0);
        if (rdy) begin
          check_eq("pixel", sval(dout_data), exp_q[got]);
          got++;
          hs_edge = cyc + 1;
        end
      end else begin
        rdy = $urandom_range(0, 1);
      end
      dout_ready = rdy;
      prev_v = dout_valid; prev_rdy = rdy; prev_d = dout_data;
      @(negedge clk);
      cnt++;
    end
    start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    check_eq("out_count", got, npix);
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check_eq("done_pulses", dones, 1);
    check_eq("busy_after_done", longint'(busy), 0);
    check_eq("dout_valid_idle", longint'(dout_valid), 0);
  endtask

  task automatic run_job(input int hp, input int wp, input int ic, input int oc, input int mode);
    start_and_load(hp, wp, ic, oc, mode);
    collect(ic, mode);
  endtask

  task automatic bad_start(input int hp, input int wp, input int ic, input int oc);
    @(negedge clk);
    start = 1'b1; cfg_hp = 5'(hp); cfg_wp = 5'(wp); cfg_ic = 8'(ic); cfg_oc = 8'(oc);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("cfg_err_set", longint'(cfg_err), 1);
    check_eq("cfg_busy_low", longint'(busy), 0);
    check_eq("cfg_din_ready_low", longint'(din_ready), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_din_ready"}, longint'(din_ready), 0);
    check_eq({tag, "_dout_valid"}, longint'(dout_valid), 0);
    check_eq({tag, "_dout_data"}, longint'(dout_data), 0);
    check_eq({tag, "_busy"}, longint'(busy), 0);
    check_eq({tag, "_done"}, longint'(done), 0);
    check_eq({tag, "_cfg_err"}, longint'(cfg_err), 0);
  endtask

  task automatic round_job(input logic [15:0] wt, input longint exp);
    words.delete();
    for (int i = 0; i < 18; i++) words.push_back(16'h0000);
    words[4] = 16'h0001;
    words[9 + 4] = wt;
    exp_q.delete();
    exp_q.push_back(exp);
    run_job(3, 3, 1, 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");

    bad_start(2, 4, 1, 1);
    bad_start(4, 4, 0, 1);
    bad_start(4, 13, 1, 1);

    // Centre-only unit weight picks the interior pixels 5, 6, 9, 10.
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(16'(i << 10));
    for (int i = 0; i < 9; i++) words.push_back(i == 4 ? 16'h0400 : 16'h0000);
    exp_q = '{5120, 6144, 9216, 10240};
    run_job(4, 4, 1, 1, 0);
    exp_q = '{5120, 6144, 9216, 10240};
    run_job(4, 4, 1, 1, 1);

    round_job(16'h0200, 1);
    round_job(16'hFE00, 0);
`ifdef CONV_CORE_RELU_EN
    round_job(16'hFDFF, 0);
`else
    round_job(16'hFDFF, -1);
`endif

    // Full-size image and channel depth with all-ones data saturates.
    make_words(12, 12, 12, 2, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back(32767);
    run_job(12, 12, 12, 2, 0);

    make_words(3, 3, 12, 12, 1'b0);
    build_model(3, 3, 12, 12);
    run_job(3, 3, 12, 12, 2);

    for (int j = 0; j < 6; j++) begin
      int hp, wp, ic, oc;
      hp = $urandom_range(3, 6); wp = $urandom_range(3, 6);
      ic = $urandom_range(1, 3); oc = $urandom_range(1, 3);
      make_words(hp, wp, ic, oc, 1'b0);
      build_model(hp, wp, ic, oc);
      run_job(hp, wp, ic, oc, 2);
    end

    // Abort mid-computation, then a fresh job must still be correct.
    make_words(4, 4, 2, 1, 1'b0);
    start_and_load(4, 4, 2, 1, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort_now");
    @(negedge clk);
    check_reset_outputs("abort_next");
    rst_n = 1'b1;
    make_words(5, 4, 2, 2, 1'b0);
    build_model(5, 4, 2, 2);
    run_job(5, 4, 2, 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
